tmr_vote_monitor: RTL and testbench
===================================

// Module: tmr_vote_monitor
// PURPOSE
//  Registered majority voter and fault monitor for three redundant ALU32 lanes.
//  Takes each lane's {result, carry_out} and produces one voted word.
//  Counts per-lane upsets and retires a lane that stays wrong.
//  Degrades TRIPLEX -> DUPLEX -> FAILED; receives the SEU-corrupted lane outputs.
// PARAMETERS
//  WIDTH         32  result width per lane (carry adds 1 bit to the voted word)
//  CNT_W         16  width of each per-lane saturating error counter
//  FAULT_THRESH   4  consecutive valid mismatches that retire a lane (>=1)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      async active-low reset
//  in_valid      in   1      lane inputs valid this cycle
//  r1,r2,r3      in   WIDTH  lane results
//  c1,c2,c3      in   1      lane carry outs
//  clr_counts    in   1      sync clear of err_cnt1..3 (faults untouched)
//  out_valid     out  1      voted outputs valid
//  voted_result  out  WIDTH  voted result
//  voted_c_out   out  1      voted carry
//  err_flag      out  1      >=1 active lane disagreed with voted word
//  uncorrectable out  1      no trustworthy majority
//  lane_fault    out  3      bit k-1 = lane k retired (sticky until reset)
//  err_cnt1..3   out  CNT_W  per-lane mismatch totals, saturating
//  mode          out  2      0 TRIPLEX, 1 DUPLEX, 2 FAILED
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; mode=TRIPLEX; consecutive counters 0.
//  Word Wk = {ck, rk}, WIDTH+1 bits. All outputs registered; latency 1 clk.
//  out_valid(t+1)=in_valid(t). Cycles with in_valid=0 hold data outputs.
//  Cycles with in_valid=0 change no counters or state.
//  TRIPLEX: V = bitwise majority (W1&W2)|(W1&W3)|(W2&W3).
//   Lane k mismatches when Wk!=V.
//   uncorrectable=1 for that sample if no two lanes are word-equal.
//   The output is still V in that case, and the state stays TRIPLEX.
//  DUPLEX (one lane retired): V = lower-index healthy lane.
//   If the two healthy lanes differ: uncorrectable=1, err_flag=1.
//   Both healthy lanes count a mismatch; mode -> FAILED next cycle.
//  FAILED: V = lowest-index unretired lane (lane 1 if all retired).
//   uncorrectable held 1 until reset. No further retirement. Counters still count.
//  err_flag = OR of mismatches among unretired lanes for that sample.
//  Retired lanes are ignored and never counted.
//  err_cntk += 1 on each mismatch of lane k; saturates at 2^CNT_W-1.
//  clr_counts wins over a same-cycle increment; the result is 0.
//  Consec counter k: +1 on mismatch, cleared on match.
//   Reaching FAULT_THRESH sets lane_fault[k-1].
//  Retirement takes effect from the next sample. TRIPLEX->DUPLEX on first retirement.
//  Two lanes reaching threshold in the same sample: both retire, mode -> FAILED.
//  Reset mid-operation: everything returns to reset values immediately;
//   the first post-reset sample is voted in TRIPLEX.
// TESTING (WIDTH=32, FAULT_THRESH=4)
//  1. r1=r2=r3=0x12345678, c=0 -> voted 0x12345678 one cycle later; err_flag=0.
//  2. r2=0xFFFF0000, others 0x0000FFFF -> voted 0x0000FFFF, err_flag=1, err_cnt2=1.
//  3. Lane3 wrong 4 consecutive samples -> lane_fault=3'b100, mode=1.
//     Same lane wrong 3x then right -> no retirement.
//  4. DUPLEX, then r1=1,r2=2 -> uncorrectable=1, mode=2.
//     uncorrectable stays 1 with clean inputs; rst_n low clears all.
//  5. r1=1,r2=2,r3=4 in TRIPLEX -> voted 0, uncorrectable=1 that sample only.
//  6. err_cnt at 0xFFFF + mismatch -> stays 0xFFFF.
//     clr_counts with a mismatch -> 0; in_valid=0 -> all counts unchanged.

Source files
------------

// File: rtl/tmr_vote_monitor.sv
// Registered majority voter and fault monitor for three redundant ALU lanes.
// Each lane word is {carry, result}; the voted word, health flags, per-lane
// error totals and the redundancy mode all update one clock after a valid sample.
module tmr_vote_monitor #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [WIDTH-1:0] r3,
  input  logic             c1,
  input  logic             c2,
  input  logic             c3,
  input  logic             clr_counts,
  output logic             out_valid,
  output logic [WIDTH-1:0] voted_result,
  output logic             voted_c_out,
  output logic             err_flag,
  output logic             uncorrectable,
  output logic [2:0]       lane_fault,
  output logic [CNT_W-1:0] err_cnt1,
  output logic [CNT_W-1:0] err_cnt2,
  output logic [CNT_W-1:0] err_cnt3,
  output logic [1:0]       mode
);

  localparam int unsigned WW = WIDTH + 1;
  localparam int unsigned CW = $clog2(FAULT_THRESH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CW-1:0]    CONSEC_LAST = CW'(FAULT_THRESH - 1);
  localparam logic [CW-1:0]    CONSEC_CAP  = CW'(FAULT_THRESH);

  typedef enum logic [1:0] {
    TRIPLEX = 2'd0,
    DUPLEX  = 2'd1,
    FAILED  = 2'd2
  } mode_t;

  mode_t            mode_q, mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WW-1:0]    voted_q, voted_d;
  logic             err_flag_q, err_flag_d;
  logic             unc_q, unc_d;
  logic [2:0]       fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [CW-1:0]    consec_q [3];
  logic [CW-1:0]    consec_d [3];

  logic [WW-1:0]    w [3];
  logic [WW-1:0]    maj;
  logic [WW-1:0]    lowest;
  logic [WW-1:0]    vote;
  logic [2:0]       healthy;
  logic [2:0]       mism_raw;
  logic [2:0]       mism;
  logic [2:0]       at_last;
  logic [2:0]       retire;
  logic             any_pair_eq;
  logic             samp_unc;

  // State register: every output comes straight from a flop here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= TRIPLEX;
      out_valid_q <= 1'b0;
      voted_q     <= '0;
      err_flag_q  <= 1'b0;
      unc_q       <= 1'b0;
      fault_q     <= '0;
      cnt_q       <= '{default: '0};
      consec_q    <= '{default: '0};
    end else begin
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      voted_q     <= voted_d;
      err_flag_q  <= err_flag_d;
      unc_q       <= unc_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
      consec_q    <= consec_d;
    end
  end

  // Vote, classify lanes and compute every next-state value.
  always_comb begin
    w[0] = {c1, r1};
    w[1] = {c2, r2};
    w[2] = {c3, r3};
    healthy     = ~fault_q;
    maj         = (w[0] & w[1]) | (w[0] & w[2]) | (w[1] & w[2]);
    any_pair_eq = (w[0] == w[1]) || (w[0] == w[2]) || (w[1] == w[2]);

    // Lowest-index unretired lane; lane 1 when nothing is left.
    if (healthy[0])      lowest = w[0];
    else if (healthy[1]) lowest = w[1];
    else if (healthy[2]) lowest = w[2];
    else                 lowest = w[0];

    vote     = lowest;
    samp_unc = 1'b0;
    mism     = '0;
    if (mode_q == TRIPLEX) begin
      vote     = maj;
      samp_unc = !any_pair_eq;
    end

    for (int k = 0; k < 3; k++) begin
      mism_raw[k] = healthy[k] && (w[k] != vote);
      at_last[k]  = (consec_q[k] == CONSEC_LAST);
    end

    case (mode_q)
      TRIPLEX: mism = mism_raw;
      DUPLEX: begin
        // A disagreement between the two survivors blames both of them.
        samp_unc = |mism_raw;
        mism     = samp_unc ? healthy : 3'b000;
      end
      default: begin
        samp_unc = 1'b1;
        mism     = mism_raw;
      end
    endcase

    retire = (mode_q != FAILED) ? (mism & at_last) : 3'b000;

    mode_d      = mode_q;
    out_valid_d = in_valid;
    voted_d     = voted_q;
    err_flag_d  = err_flag_q;
    unc_d       = unc_q;
    fault_d     = fault_q;
    cnt_d       = cnt_q;
    consec_d    = consec_q;

    if (in_valid) begin
      voted_d    = vote;
      err_flag_d = |mism;
      fault_d    = fault_q | retire;
      for (int k = 0; k < 3; k++) begin
        if (mism[k]) begin
          consec_d[k] = (consec_q[k] == CONSEC_CAP) ? CONSEC_CAP : consec_q[k] + CW'(1);
          if (cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end else begin
          consec_d[k] = '0;
        end
      end
      if (mode_q == FAILED) begin
        mode_d = FAILED;
      end else if ((mode_q == DUPLEX && samp_unc) || ($countones(fault_d) >= 2)) begin
        mode_d = FAILED;
      end else if ($countones(fault_d) == 1) begin
        mode_d = DUPLEX;
      end else begin
        mode_d = TRIPLEX;
      end
      unc_d = samp_unc || (mode_d == FAILED);
    end

    if (clr_counts) cnt_d = '{default: '0};
  end

  assign out_valid     = out_valid_q;
  assign voted_result  = voted_q[WIDTH-1:0];
  assign voted_c_out   = voted_q[WIDTH];
  assign err_flag      = err_flag_q;
  assign uncorrectable = unc_q;
  assign lane_fault    = fault_q;
  assign err_cnt1      = cnt_q[0];
  assign err_cnt2      = cnt_q[1];
  assign err_cnt3      = cnt_q[2];
  assign mode          = mode_q;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Self-checking bench for tmr_vote_monitor: directed scenarios plus randomized
// lane corruption, compared each cycle against a sample-level reference model.
module tb_tmr_vote_monitor;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 16;
  localparam int          THR   = 4;
  localparam int          CMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] r1, r2, r3;
  logic        c1, c2, c3;
  logic        clr_counts;
  logic        out_valid;
  logic [31:0] voted_result;
  logic        voted_c_out;
  logic        err_flag;
  logic        uncorrectable;
  logic [2:0]  lane_fault;
  logic [15:0] err_cnt1, err_cnt2, err_cnt3;
  logic [1:0]  mode;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int        m_mode;
  bit [2:0]  m_fault;
  int        m_consec [3];
  int        m_cnt [3];
  bit        m_ov;
  bit [32:0] m_v;
  bit        m_ef;
  bit        m_unc;

  always #5 clk = ~clk;

  tmr_vote_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FAULT_THRESH(THR)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .r1(r1), .r2(r2), .r3(r3), .c1(c1), .c2(c2), .c3(c3),
    .clr_counts(clr_counts), .out_valid(out_valid),
    .voted_result(voted_result), .voted_c_out(voted_c_out),
    .err_flag(err_flag), .uncorrectable(uncorrectable),
    .lane_fault(lane_fault), .err_cnt1(err_cnt1), .err_cnt2(err_cnt2),
    .err_cnt3(err_cnt3), .mode(mode)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [32:0] bit_majority(input bit [32:0] a, input bit [32:0] b, input bit [32:0] c);
    bit [32:0] r;
    for (int i = 0; i < 33; i++) begin
      int n;
      n = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (n >= 2);
    end
    return r;
  endfunction

  function automatic bit [32:0] corrupt(input bit [32:0] b);
    bit [32:0] m;
    m = {1'($urandom_range(0, 1)), $urandom};
    if (m == 33'd0) m = 33'd1;
    return b ^ m;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fault = 3'b000; m_ov = 0; m_v = '0; m_ef = 0; m_unc = 0;
    for (int k = 0; k < 3; k++) begin
      m_consec[k] = 0;
      m_cnt[k] = 0;
    end
  endtask

  // One sample of the specified behaviour, in terms of whole-word comparisons.
  task automatic model_step(input bit v, input bit [32:0] w0, input bit [32:0] w1,
                            input bit [32:0] w2, input bit clr);
    bit [32:0] w [3];
    bit        mism [3];
    bit        fail_now;
    int        a, b, nret;
    w[0] = w0; w[1] = w1; w[2] = w2;
    m_ov = v;
    if (v) begin
      mism = '{0, 0, 0};
      fail_now = 0;
      m_unc = 0;
      if (m_mode == 0) begin
        if (w[0] == w[1] || w[0] == w[2]) m_v = w[0];
        else if (w[1] == w[2]) m_v = w[1];
        else begin
          m_v = bit_majority(w[0], w[1], w[2]);
          m_unc = 1;
        end
        for (int k = 0; k < 3; k++) mism[k] = (w[k] != m_v);
      end else if (m_mode == 1) begin
        a = -1; b = -1;
        for (int k = 0; k < 3; k++)
          if (!m_fault[k]) begin
            if (a < 0) a = k; else b = k;
          end
        m_v = w[a];
        if (w[a] != w[b]) begin
          m_unc = 1; mism[a] = 1; mism[b] = 1; fail_now = 1;
        end
      end else begin
        a = 0;
        for (int k = 2; k >= 0; k--) if (!m_fault[k]) a = k;
        m_v = w[a];
        m_unc = 1;
        for (int k = 0; k < 3; k++) mism[k] = !m_fault[k] && (w[k] != m_v);
      end
      m_ef = mism[0] || mism[1] || mism[2];
      for (int k = 0; k < 3; k++) begin
        if (mism[k] && m_cnt[k] < CMAX) m_cnt[k]++;
        m_consec[k] = mism[k] ? m_consec[k] + 1 : 0;
        if (m_mode != 2 && mism[k] && m_consec[k] >= THR) m_fault[k] = 1;
      end
      nret = $countones(m_fault);
      if (m_mode != 2) begin
        if (fail_now || nret >= 2) m_mode = 2;
        else if (nret == 1) m_mode = 1;
      end
      if (m_mode == 2) m_unc = 1;
    end
    if (clr) for (int k = 0; k < 3; k++) m_cnt[k] = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq($sformatf("%s.out_valid", tag), 64'(out_valid), 64'(m_ov));
    check_eq($sformatf("%s.voted", tag), 64'({voted_c_out, voted_result}), 64'(m_v));
    check_eq($sformatf("%s.err_flag", tag), 64'(err_flag), 64'(m_ef));
    check_eq($sformatf("%s.uncorrectable", tag), 64'(uncorrectable), 64'(m_unc));
    check_eq($sformatf("%s.lane_fault", tag), 64'(lane_fault), 64'(m_fault));
    check_eq($sformatf("%s.err_cnt1", tag), 64'(err_cnt1), 64'(m_cnt[0]));
    check_eq($sformatf("%s.err_cnt2", tag), 64'(err_cnt2), 64'(m_cnt[1]));
    check_eq($sformatf("%s.err_cnt3", tag), 64'(err_cnt3), 64'(m_cnt[2]));
    check_eq($sformatf("%s.mode", tag), 64'(mode), 64'(m_mode));
  endtask

  task automatic step(input bit v, input bit [32:0] w0, input bit [32:0] w1,
                      input bit [32:0] w2, input bit clr, input bit chk, input string tag);
    @(negedge clk);
    in_valid = v;
    {c1, r1} = w0; {c2, r2} = w1; {c3, r3} = w2;
    clr_counts = clr;
    @(posedge clk);
    #1;
    model_step(v, w0, w1, w2, clr);
    if (chk) check_all(tag);
  endtask

  // Asynchronous reset asserted away from the clock edge, checked before release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    clr_counts = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit [32:0] g, bad, base, lw [3];
    int sticky;
    rst_n = 1'b0; in_valid = 1'b0; clr_counts = 1'b0;
    r1 = '0; r2 = '0; r3 = '0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
    model_reset();
    do_reset("reset");
    check_eq("reset_mode", 64'(mode), 64'd0);

    // Clean triplex sample
    g = {1'b0, 32'h12345678};
    step(1, g, g, g, 0, 1, "t1");
    check_eq("t1_voted", 64'(voted_result), 64'h12345678);
    check_eq("t1_err_flag", 64'(err_flag), 64'd0);

    // Single-lane upset corrected
    step(1, {1'b0, 32'h0000FFFF}, {1'b0, 32'hFFFF0000}, {1'b0, 32'h0000FFFF}, 0, 1, "t2");
    check_eq("t2_voted", 64'(voted_result), 64'h0000FFFF);
    check_eq("t2_err_flag", 64'(err_flag), 64'd1);
    check_eq("t2_err_cnt2", 64'(err_cnt2), 64'd1);

    // Three wrong then right: no retirement; then four wrong retires lane 3
    do_reset("t3_rst");
    g = {1'b0, 32'hCAFEF00D};
    bad = {1'b1, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) step(1, g, g, bad, 0, 1, "t3_short");
    step(1, g, g, g, 0, 1, "t3_recover");
    check_eq("t3_no_retire", 64'(lane_fault), 64'd0);
    check_eq("t3_cnt3_a", 64'(err_cnt3), 64'd3);
    for (int i = 0; i < 4; i++) step(1, g, g, bad, 0, 1, "t3_run");
    check_eq("t3_lane_fault", 64'(lane_fault), 64'b100);
    check_eq("t3_mode", 64'(mode), 64'd1);
    check_eq("t3_cnt3_b", 64'(err_cnt3), 64'd7);

    // Duplex disagreement fails the unit; uncorrectable is sticky
    step(1, 33'd1, 33'd2, 33'h1_DEAD_BEEF, 0, 1, "t4");
    check_eq("t4_unc", 64'(uncorrectable), 64'd1);
    check_eq("t4_mode", 64'(mode), 64'd2);
    check_eq("t4_cnt1", 64'(err_cnt1), 64'd1);
    check_eq("t4_cnt3_retired", 64'(err_cnt3), 64'd7);
    for (int i = 0; i < 3; i++) step(1, g, g, g, 0, 1, "t4_clean");
    check_eq("t4_unc_sticky", 64'(uncorrectable), 64'd1);

    // Saturation in FAILED mode (lane 2 keeps disagreeing with lane 1)
    bad = {1'b0, 32'h0BADF00D};
    for (int i = 0; i < CMAX - 1; i++) step(1, g, bad, g, 0, 0, "t6_fill");
    check_eq("t6_cnt2_full", 64'(err_cnt2), 64'hFFFF);
    step(1, g, bad, g, 0, 1, "t6_sat");
    check_eq("t6_cnt2_sat", 64'(err_cnt2), 64'hFFFF);
    step(1, g, bad, g, 1, 1, "t6_clr");
    check_eq("t6_cnt2_clr", 64'(err_cnt2), 64'd0);
    step(1, g, bad, g, 0, 1, "t6_inc");
    step(0, bad, bad, bad, 0, 1, "t6_idle");
    check_eq("t6_idle_cnt2", 64'(err_cnt2), 64'd1);
    check_eq("t6_idle_voted", 64'(voted_result), 64'hCAFEF00D);
    check_eq("t6_idle_ov", 64'(out_valid), 64'd0);

    // Mid-operation reset, then no-majority sample in triplex
    do_reset("t4_rst");
    check_eq("t4_rst_mode", 64'(mode), 64'd0);
    check_eq("t4_rst_unc", 64'(uncorrectable), 64'd0);
    step(1, 33'd1, 33'd2, 33'd4, 0, 1, "t5");
    check_eq("t5_voted", 64'({voted_c_out, voted_result}), 64'd0);
    check_eq("t5_unc", 64'(uncorrectable), 64'd1);
    step(1, g, g, g, 0, 1, "t5_next");
    check_eq("t5_unc_clear", 64'(uncorrectable), 64'd0);
    check_eq("t5_mode", 64'(mode), 64'd0);

    // Randomized lane corruption with one lane biased towards persistent faults
    for (int round = 0; round < 20; round++) begin
      do_reset("rnd_rst");
      sticky = $urandom_range(0, 2);
      for (int i = 0; i < 150; i++) begin
        bit v, clr;
        base = {1'($urandom_range(0, 1)), $urandom};
        for (int k = 0; k < 3; k++) begin
          int pct;
          pct = (k == sticky) ? 75 : 6;
          lw[k] = ($urandom_range(0, 99) < pct) ? corrupt(base) : base;
        end
        v = ($urandom_range(0, 7) != 0);
        clr = v && ($urandom_range(0, 31) == 0);
        step(v, lw[0], lw[1], lw[2], clr, 1, "rnd");
        if ($urandom_range(0, 199) == 0) do_reset("rnd_midrst");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
